// File: rtl/pre_if_fetch_unit_pkg.sv
// Shared types and constants for the pre-IF fetch unit: reset/exception
// addresses, branch bus width and the redirect descriptor with its merge rule.
package pre_if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'hbfc00000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;

    // {br_stall, br_taken, br_target}
    localparam int BR_BUS_WD = 34;

    // Encoding order is the redirect priority: larger value wins.
    typedef enum logic [1:0] {
        REDIR_NONE = 2'd0,
        REDIR_BR   = 2'd1,
        REDIR_EXC  = 2'd2,
        REDIR_ERET = 2'd3
    } redir_kind_e;

    typedef struct packed {
        redir_kind_e kind;
        logic [31:0] target;
    } redir_t;

    // An arriving redirect replaces the stored one unless the stored one
    // has strictly higher priority.
    function automatic redir_t redir_merge(input redir_t pend, input redir_t arriving);
        redir_t res;
        if ((arriving.kind != REDIR_NONE) && (arriving.kind >= pend.kind)) begin
            res = arriving;
        end else begin
            res = pend;
        end
        return res;
    endfunction

endpackage

// File: rtl/fetch_inflight_ctr.sv
// Tracks ICache requests accepted but not yet answered, and how many of
// those answers must be dropped after a flush/ERET redirect.
module fetch_inflight_ctr #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic accept_i,
    input  logic data_ok_i,
    input  logic redirect_i,
    output logic full_o,
    output logic discard_o
);
    localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZER = {CNT_W{1'b0}};

    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

    // Next-state for both counters; a flush snapshot uses the post-update count.
    always_comb begin
        full_o    = (inflight_q == CNT_MAX);
        discard_o = ~reset & data_ok_i & (discard_cnt_q != CNT_ZER);

        case ({accept_i, data_ok_i})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01: begin
                if (inflight_q != CNT_ZER) begin
                    inflight_d = inflight_q - CNT_ONE;
                end else begin
                    inflight_d = inflight_q;
                end
            end
            default: inflight_d = inflight_q;
        endcase

        if (redirect_i) begin
            discard_cnt_d = inflight_d;
        end else if (discard_o) begin
            discard_cnt_d = discard_cnt_q - CNT_ONE;
        end else begin
            discard_cnt_d = discard_cnt_q;
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q    <= CNT_ZER;
            discard_cnt_q <= CNT_ZER;
        end else begin
            inflight_q    <= inflight_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

endmodule

// File: rtl/pre_if_fetch_unit.sv
// Pre-IF stage: generates block-aligned ICache requests, applies branch,
// exception and ERET redirects, and presents the fetch PC to IF.
module pre_if_fetch_unit
    import pre_if_fetch_unit_pkg::*;
#(
    parameter int          FETCH_WIDTH     = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
    parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fs_allowin,
    input  logic                   br_stall,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    input  logic                   mfc0_stall,
    input  logic                   flush,
    input  logic                   m1s_inst_eret,
    input  logic [31:0]            CP0_EPC_out,
    output logic                   inst_valid,
    output logic                   inst_op,
    output logic [31:0]            inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    output logic                   ps_to_fs_valid,
    output logic [31:0]            ps_to_fs_pc,
    output logic [FETCH_WIDTH-1:0] ps_to_fs_slot_mask,
    output logic                   ps_to_fs_adel,
    output logic                   resp_discard
);
    localparam logic [31:0] BLK_BYTES = 32'(4 * FETCH_WIDTH);
    localparam logic [31:0] BLK_MASK  = BLK_BYTES - 32'd1;
    localparam logic [31:0] SLOT_MASK = 32'(FETCH_WIDTH - 1);
    localparam redir_t      NO_REDIR  = '{kind: REDIR_NONE, target: 32'd0};

    logic [31:0]          fetch_pc_q, fetch_pc_d;
    redir_t               pend_q, pend_d;
    redir_t               arriving_s, eff_s;
    logic [BR_BUS_WD-1:0] br_bus_s;
    logic [31:0]          aligned_pc_s, seq_pc_s, word_off_s;
    logic                 full_s, misaligned_s, accept_s, redirect_exc_s;

    // Pick the highest-priority redirect arriving this cycle.
    always_comb begin
        br_bus_s       = {br_stall, br_taken, br_target};
        redirect_exc_s = flush | m1s_inst_eret;
        if (m1s_inst_eret) begin
            arriving_s = '{kind: REDIR_ERET, target: CP0_EPC_out};
        end else if (flush) begin
            arriving_s = '{kind: REDIR_EXC, target: EXC_VECTOR};
        end else if (br_bus_s[32] & ~br_bus_s[33] & ~mfc0_stall) begin
            arriving_s = '{kind: REDIR_BR, target: br_bus_s[31:0]};
        end else begin
            arriving_s = NO_REDIR;
        end
    end

    // Request generation, block alignment and IF bus outputs.
    always_comb begin
        aligned_pc_s   = fetch_pc_q & ~BLK_MASK;
        seq_pc_s       = aligned_pc_s + BLK_BYTES;
        word_off_s     = (fetch_pc_q >> 2) & SLOT_MASK;
        misaligned_s   = |fetch_pc_q[1:0];
        inst_valid     = ~reset & fs_allowin & ~full_s & ~misaligned_s;
        accept_s       = inst_valid & inst_addr_ok;
        inst_op        = 1'b0;
        inst_addr      = aligned_pc_s;
        ps_to_fs_pc    = fetch_pc_q;
        ps_to_fs_valid = ~reset & (accept_s | (misaligned_s & fs_allowin));
        ps_to_fs_adel  = ~reset & misaligned_s;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            ps_to_fs_slot_mask[i] = (32'(i) >= word_off_s);
        end
    end

    // Fetch PC / pending redirect next-state. inst_addr may only move while
    // no request is on the bus, so non-branch redirects wait for that.
    always_comb begin
        eff_s      = redir_merge(pend_q, arriving_s);
        fetch_pc_d = fetch_pc_q;
        pend_d     = pend_q;
        if (accept_s) begin
            if (eff_s.kind != REDIR_NONE) begin
                fetch_pc_d = eff_s.target;
            end else begin
                fetch_pc_d = seq_pc_s;
            end
            pend_d = NO_REDIR;
        end else if (eff_s.kind == REDIR_NONE) begin
            pend_d = pend_q;
        end else if ((eff_s.kind != REDIR_BR) && !inst_valid) begin
            fetch_pc_d = eff_s.target;
            pend_d     = NO_REDIR;
        end else begin
            pend_d = eff_s;
        end
    end

    // Fetch PC and pending redirect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            pend_q     <= NO_REDIR;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pend_q     <= pend_d;
        end
    end

    fetch_inflight_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_ctr (
        .clk        (clk),
        .reset      (reset),
        .accept_i   (accept_s),
        .data_ok_i  (inst_data_ok),
        .redirect_i (redirect_exc_s),
        .full_o     (full_s),
        .discard_o  (resp_discard)
    );

endmodule

// File: tb/tb_pre_if_fetch_unit.sv
// Scoreboard bench for pre_if_fetch_unit with FETCH_WIDTH=2, MAX_OUTSTANDING=2.
module tb_pre_if_fetch_unit;
    localparam int          FW     = 2;
    localparam int          MAXO   = 2;
    localparam logic [31:0] RST_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_PC = 32'hbfc00380;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fs_allowin = 1'b0, br_stall = 1'b0, br_taken = 1'b0, mfc0_stall = 1'b0;
    logic [31:0]   br_target = 32'd0, CP0_EPC_out = 32'd0;
    logic          flush = 1'b0, m1s_inst_eret = 1'b0;
    logic          inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
    logic          inst_valid, inst_op, ps_to_fs_valid, ps_to_fs_adel, resp_discard;
    logic [31:0]   inst_addr, ps_to_fs_pc;
    logic [FW-1:0] ps_to_fs_slot_mask;

    always #5 clk = ~clk;

    pre_if_fetch_unit #(
        .FETCH_WIDTH     (FW),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RST_PC),
        .EXC_VECTOR      (EXC_PC)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .fs_allowin         (fs_allowin),
        .br_stall           (br_stall),
        .br_taken           (br_taken),
        .br_target          (br_target),
        .mfc0_stall         (mfc0_stall),
        .flush              (flush),
        .m1s_inst_eret      (m1s_inst_eret),
        .CP0_EPC_out        (CP0_EPC_out),
        .inst_valid         (inst_valid),
        .inst_op            (inst_op),
        .inst_addr          (inst_addr),
        .inst_addr_ok       (inst_addr_ok),
        .inst_data_ok       (inst_data_ok),
        .ps_to_fs_valid     (ps_to_fs_valid),
        .ps_to_fs_pc        (ps_to_fs_pc),
        .ps_to_fs_slot_mask (ps_to_fs_slot_mask),
        .ps_to_fs_adel      (ps_to_fs_adel),
        .resp_discard       (resp_discard)
    );

    typedef struct { logic iv; logic psv; logic adel; logic disc; } cyc_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] pc; logic [FW-1:0] mask; } acc_exp_t;

    cyc_exp_t cyc_q[$];
    acc_exp_t acc_q[$];
    cyc_exp_t mon_ce;
    acc_exp_t mon_ae;
    int checks = 0;
    int errors = 0;

    // Reference model state (values after the most recent clock edge)
    logic [31:0] m_pc = RST_PC;
    int          m_infl = 0;
    int          m_disc = 0;
    int          m_pend_prio = 0;   // 0 none, 1 branch, 2 exception, 3 eret
    logic [31:0] m_pend_tgt = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] blk_base(input logic [31:0] pc);
        return pc - (pc % 32'(4 * FW));
    endfunction

    function automatic logic [FW-1:0] exp_mask(input logic [31:0] pc);
        logic [FW-1:0] m;
        int off;
        off = int'((pc / 32'd4) % 32'(FW));
        for (int i = 0; i < FW; i++) m[i] = (i >= off);
        return m;
    endfunction

    // Drive one cycle of inputs, record what the DUT must show, advance the model.
    task automatic drive(input logic r, input logic al, input logic aok, input logic dok,
                         input logic bt, input logic bs, input logic mst, input logic [31:0] btgt,
                         input logic fl, input logic er, input logic [31:0] epc);
        cyc_exp_t ce;
        acc_exp_t ae;
        logic mis, mv, acc, mdisc;
        int new_prio;
        logic [31:0] new_tgt;
        @(posedge clk);
        #1;
        reset = r; fs_allowin = al; inst_addr_ok = aok; inst_data_ok = dok;
        br_taken = bt; br_stall = bs; mfc0_stall = mst; br_target = btgt;
        flush = fl; m1s_inst_eret = er; CP0_EPC_out = epc;

        mis   = (m_pc % 32'd4) != 32'd0;
        mv    = !r && al && (m_infl < MAXO) && !mis;
        acc   = mv && aok;
        mdisc = !r && dok && (m_disc > 0);
        ce = '{iv: mv, psv: (!r && (acc || (mis && al))), adel: (!r && mis), disc: mdisc};
        cyc_q.push_back(ce);
        if (acc) begin
            ae = '{addr: blk_base(m_pc), pc: m_pc, mask: exp_mask(m_pc)};
            acc_q.push_back(ae);
        end

        if (r) begin
            m_pc = RST_PC; m_infl = 0; m_disc = 0; m_pend_prio = 0;
        end else begin
            if (er)                    begin new_prio = 3; new_tgt = epc;    end
            else if (fl)               begin new_prio = 2; new_tgt = EXC_PC; end
            else if (bt && !bs && !mst) begin new_prio = 1; new_tgt = btgt;  end
            else                       begin new_prio = 0; new_tgt = 32'd0;  end
            if (new_prio > 0 && new_prio >= m_pend_prio) begin
                m_pend_prio = new_prio;
                m_pend_tgt  = new_tgt;
            end
            if (acc) begin
                m_pc = (m_pend_prio > 0) ? m_pend_tgt : blk_base(m_pc) + 32'(4 * FW);
                m_pend_prio = 0;
            end else if (m_pend_prio >= 2 && !mv) begin
                m_pc = m_pend_tgt;
                m_pend_prio = 0;
            end
            if (acc && !dok) m_infl++;
            else if (dok && !acc && m_infl > 0) m_infl--;
            if (fl || er) m_disc = m_infl;
            else if (mdisc) m_disc--;
        end
    endtask

    task automatic step(input logic r, input logic al, input logic aok, input logic dok);
        drive(r, al, aok, dok, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Monitor: compare DUT outputs against queued expectations each cycle.
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_ce = cyc_q.pop_front();
            check("inst_valid", 32'(inst_valid), 32'(mon_ce.iv));
            check("ps_to_fs_valid", 32'(ps_to_fs_valid), 32'(mon_ce.psv));
            check("ps_to_fs_adel", 32'(ps_to_fs_adel), 32'(mon_ce.adel));
            check("resp_discard", 32'(resp_discard), 32'(mon_ce.disc));
            check("inst_op", 32'(inst_op), 32'd0);
            if (inst_valid && inst_addr_ok) begin
                if (acc_q.size() == 0) begin
                    check("unexpected_accept", 32'd1, 32'd0);
                end else begin
                    mon_ae = acc_q.pop_front();
                    check("acc_inst_addr", inst_addr, mon_ae.addr);
                    check("acc_pc", ps_to_fs_pc, mon_ae.pc);
                    check("acc_mask", 32'(ps_to_fs_slot_mask), 32'(mon_ae.mask));
                end
            end
        end
    end

    initial begin
        // Reset
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        #2 check("rst_inst_valid", 32'(inst_valid), 32'd0);
        // Sequential fetch and outstanding limit
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("seq_addr0", inst_addr, 32'hbfc00000);
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("seq_addr1", inst_addr, 32'hbfc00008);
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("full_no_req_a", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("full_no_req_b", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1); #2 check("full_no_req_c", 32'(inst_valid), 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("seq_addr2", inst_addr, 32'hbfc00010);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // Branch arriving while the bus stalls
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80001004, 1'b0, 1'b0, 32'd0);
        #2 check("br_hold0", inst_addr, 32'hbfc00018);
        step(1'b0, 1'b1, 1'b0, 1'b0); #2 check("br_hold1", inst_addr, 32'hbfc00018);
        step(1'b0, 1'b1, 1'b0, 1'b0); #2 check("br_hold2", inst_addr, 32'hbfc00018);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        #2 check("br_tgt_addr", inst_addr, 32'h80001000);
        check("br_tgt_mask", 32'(ps_to_fs_slot_mask), 32'd2);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // Flush and ERET together: ERET wins
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h80002000);
        step(1'b0, 1'b1, 1'b0, 1'b0); #2 check("eret_addr", inst_addr, 32'h80002000);
        // Flush with two in flight
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1); #2 check("discard0", 32'(resp_discard), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1); #2 check("discard1", 32'(resp_discard), 32'd1);
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("exc_addr", inst_addr, EXC_PC);
        step(1'b0, 1'b0, 1'b0, 1'b1); #2 check("exc_kept", 32'(resp_discard), 32'd0);
        // Misaligned branch target, then flush
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80000002, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        #2 check("adel_flag", 32'(ps_to_fs_adel), 32'd1);
        check("adel_no_req", 32'(inst_valid), 32'd0);
        check("adel_valid", 32'(ps_to_fs_valid), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0); #2 check("adel_resume", inst_addr, EXC_PC);
        // Address wrap past 0xfffffffc
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hfffffffc, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0); #2 check("wrap_top", inst_addr, 32'hfffffff8);
        step(1'b0, 1'b1, 1'b1, 1'b1); #2 check("wrap_zero", inst_addr, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic r, al, aok, dok, bt, bs, mst, fl, er;
            logic [31:0] tgt, epc;
            r   = ($urandom_range(0, 99) < 2);
            al  = ($urandom_range(0, 3) != 0);
            aok = ($urandom_range(0, 1) == 1);
            dok = (m_infl > 0) ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
            bt  = ($urandom_range(0, 99) < 12);
            bs  = ($urandom_range(0, 99) < 20);
            mst = ($urandom_range(0, 99) < 20);
            tgt = $urandom();
            if ($urandom_range(0, 99) < 90) tgt = tgt & 32'hfffffffc;
            fl  = ($urandom_range(0, 99) < 3);
            er  = ($urandom_range(0, 99) < 2);
            epc = $urandom() & 32'hfffffffc;
            drive(r, al, aok, dok, bt, bs, mst, tgt, fl, er, epc);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("acc_queue_drained", 32'(acc_q.size()), 32'd0);
        check("cyc_queue_drained", 32'(cyc_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
